divisor_restaurador: RTL and testbench

- Sequential restoring (shift-subtract) unsigned divider.
- Inverse companion of the team's shift-add multiplier; uses the same init/done handshake style.
- Divides an N-bit dividend by an M-bit divisor, producing quotient and remainder.
- Feeds the board display path alongside the multiplier result.

---
 rtl/divisor_restaurador_if.sv | 24 ++
 rtl/divisor_restaurador.sv | 122 ++++++++++++
 tb/tb_divisor_restaurador.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/divisor_restaurador_if.sv
// Handshake and operand/result bundle for the restoring divider.
// master drives the operands and init; slave is the divider itself.
interface divisor_restaurador_if #(
    parameter int N_DIVIDENDO = 8,
    parameter int M_DIVISOR   = 4
);
    logic                   init;
    logic [N_DIVIDENDO-1:0] dividendo;
    logic [M_DIVISOR-1:0]   divisor;
    logic [N_DIVIDENDO-1:0] cociente;
    logic [M_DIVISOR-1:0]   residuo;
    logic                   done;
    logic                   div_zero;

    modport master (
        output init, dividendo, divisor,
        input  cociente, residuo, done, div_zero
    );

    modport slave (
        input  init, dividendo, divisor,
        output cociente, residuo, done, div_zero
    );
endinterface

// File: rtl/divisor_restaurador.sv
// Sequential restoring (shift-subtract) unsigned divider: N-bit dividend by M-bit divisor.
// Optional macro DIV_ZERO_DETECT_EN short-circuits a zero divisor and raises div_zero.
module divisor_restaurador #(
    parameter int N_DIVIDENDO = 8,
    parameter int M_DIVISOR   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    divisor_restaurador_if.slave  bus
);
    localparam int CNT_W = $clog2(N_DIVIDENDO + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, SUB, DONE} state_t;

    state_t                 state_q, state_d;
    logic [N_DIVIDENDO-1:0] q_q, q_d;
    logic [M_DIVISOR:0]     a_q, a_d;
    logic [M_DIVISOR-1:0]   d_q, d_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [N_DIVIDENDO-1:0] cociente_q, cociente_d;
    logic [M_DIVISOR-1:0]   residuo_q, residuo_d;
    logic                   done_q, done_d;
`ifdef DIV_ZERO_DETECT_EN
    logic                   div_zero_q, div_zero_d;
`endif

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        a_d        = a_q;
        d_d        = d_q;
        cnt_d      = cnt_q;
        cociente_d = cociente_q;
        residuo_d  = residuo_q;
        done_d     = done_q;
`ifdef DIV_ZERO_DETECT_EN
        div_zero_d = div_zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.init) begin
                    q_d     = bus.dividendo;
                    d_d     = bus.divisor;
                    a_d     = '0;
                    cnt_d   = CNT_W'(N_DIVIDENDO);
                    done_d  = 1'b0;
                    state_d = SHIFT;
`ifdef DIV_ZERO_DETECT_EN
                    div_zero_d = 1'b0;
                    // Preload the result the full algorithm would produce and skip straight to DONE.
                    if (bus.divisor == '0) begin
                        q_d     = '1;
                        a_d     = {1'b0, bus.dividendo[M_DIVISOR-1:0]};
                        state_d = DONE;
                    end
`endif
                end
            end
            SHIFT: begin
                {a_d, q_d} = {a_q, q_q} << 1;
                state_d    = SUB;
            end
            SUB: begin
                if (a_q >= {1'b0, d_q}) begin
                    a_d    = a_q - {1'b0, d_q};
                    q_d[0] = 1'b1;
                end else begin
                    q_d[0] = 1'b0;
                end
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? DONE : SHIFT;
            end
            DONE: begin
                cociente_d = q_q;
                residuo_d  = a_q[M_DIVISOR-1:0];
                done_d     = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
                div_zero_d = (d_q == '0);
`endif
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            q_q        <= '0;
            a_q        <= '0;
            d_q        <= '0;
            cnt_q      <= '0;
            cociente_q <= '0;
            residuo_q  <= '0;
            done_q     <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            a_q        <= a_d;
            d_q        <= d_d;
            cnt_q      <= cnt_d;
            cociente_q <= cociente_d;
            residuo_q  <= residuo_d;
            done_q     <= done_d;
`ifdef DIV_ZERO_DETECT_EN
            div_zero_q <= div_zero_d;
`endif
        end
    end

    assign bus.cociente = cociente_q;
    assign bus.residuo  = residuo_q;
    assign bus.done     = done_q;
`ifdef DIV_ZERO_DETECT_EN
    assign bus.div_zero = div_zero_q;
`else
    assign bus.div_zero = 1'b0;
`endif
endmodule

// File: tb/tb_divisor_restaurador.sv
// Scoreboard bench for divisor_restaurador: stimulus pushes expected results,
// a negedge monitor pops them when done rises and checks value, flag and latency.
module tb_divisor_restaurador;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    divisor_restaurador_if #(.N_DIVIDENDO(8), .M_DIVISOR(4)) bus ();

    divisor_restaurador #(.N_DIVIDENDO(8), .M_DIVISOR(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         acc;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

`ifdef DIV_ZERO_DETECT_EN
    localparam int ZLAT = 1;
    localparam int ZFLG = 1;
`else
    localparam int ZLAT = 17;
    localparam int ZFLG = 0;
`endif

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pop on the rising of done, then confirm outputs hold while done stays high.
    initial begin : monitor
        logic done_prev;
        bit   have_cur;
        exp_t cur;
        done_prev = 1'b0;
        have_cur  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_prev = 1'b0;
                have_cur  = 1'b0;
            end else begin
                if (bus.done && !done_prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 with empty scoreboard (cycle %0d)", cyc);
                    end else begin
                        cur      = sb.pop_front();
                        have_cur = 1'b1;
                        chk("cociente", int'(bus.cociente), int'(cur.q));
                        chk("residuo", int'(bus.residuo), int'(cur.r));
                        chk("div_zero", int'(bus.div_zero), int'(cur.z));
                        chk("latency", cyc - cur.acc, cur.lat);
                    end
                end else if (bus.done && done_prev && have_cur) begin
                    chk("hold_cociente", int'(bus.cociente), int'(cur.q));
                    chk("hold_residuo", int'(bus.residuo), int'(cur.r));
                end
                done_prev = bus.done;
            end
        end
    end

    task automatic start(input int a, input int b, input int q, input int r,
                         input int z, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        bus.dividendo = a[7:0];
        bus.divisor   = b[3:0];
        bus.init      = 1'b1;
        if (push) begin
            e.q   = q[7:0];
            e.r   = r[3:0];
            e.z   = z[0];
            e.acc = cyc + 1;
            e.lat = lat;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.init      = 1'b0;
        bus.dividendo = ~a[7:0];
        bus.divisor   = ~b[3:0];
        chk("done_clr_on_accept", int'(bus.done), 0);
        chk("dz_clr_on_accept", int'(bus.div_zero), 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done=0 after %0d cycles, expected 1", n);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cociente"}, int'(bus.cociente), 0);
        chk({tag, "_residuo"}, int'(bus.residuo), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_div_zero"}, int'(bus.div_zero), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst           = 1'b1;
        bus.init      = 1'b0;
        bus.dividendo = '0;
        bus.divisor   = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // Basic divide; outputs must hold with init low.
        start(200, 7, 28, 4, 0, 17, 1);
        wait_done();
        repeat (4) @(negedge clk);

        // Back-to-back operations.
        start(255, 15, 17, 0, 0, 17, 1);
        wait_done();
        start(5, 9, 0, 5, 0, 17, 1);
        wait_done();

        // Zero divisor.
        start(100, 0, 255, 4, ZFLG, ZLAT, 1);
        wait_done();
        repeat (2) @(negedge clk);

        // init mid-division must be ignored.
        start(200, 7, 28, 4, 0, 17, 1);
        repeat (4) @(negedge clk);
        bus.dividendo = 8'd9;
        bus.divisor   = 4'd3;
        bus.init      = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
        wait_done();

        // Asynchronous reset mid-division discards the partial result.
        start(200, 7, 0, 0, 0, 17, 0);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        start(9, 3, 3, 0, 0, 17, 1);
        wait_done();

        // Sweep against a reference model.
        for (int a = 0; a < 256; a += 3) begin
            for (int b = 1; b < 16; b++) begin
                start(a, b, a / b, a % b, 0, 17, 1);
                wait_done();
            end
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
